// File: rtl/axis_word_serializer_if.sv
// Word-in / byte-out AXI-Stream bundle for axis_word_serializer.
// slave = the serializer, master = whatever drives words in and sinks bytes out.
interface axis_word_serializer_if #(
  parameter int n = 5
);
  logic [n*8-1:0] in_tdata;
  logic [n-1:0]   in_tkeep;
  logic           in_tlast;
  logic           in_tvalid;
  logic           in_tready;
  logic [7:0]     out_tdata;
  logic           out_tlast;
  logic           out_tvalid;
  logic           out_tready;
  logic           err_keep;

  modport slave (
    input  in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tlast, out_tvalid, err_keep
  );

  modport master (
    output in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tlast, out_tvalid, err_keep
  );
endinterface

// File: rtl/axis_word_serializer.sv
// n-byte word to byte serializer, LSB first; byte 0 valid the cycle after word accept.
// Backpressure: out_tready low freezes the beat; in_tready only rises on the final accepted byte.
module axis_word_serializer #(
  parameter int n  = 5,
  parameter int nb = n * 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_word_serializer_if.slave  bus
);
  localparam int W = $clog2(n + 1);
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [nb-1:0]   data_q, data_d;
  logic [W-1:0]    cnt_q, cnt_d, idx_q, idx_d, run;
  logic            last_q, last_d, err_q, err_d;
  logic            keep_bad, gap, busy, at_end, final_beat, in_xfer;
  logic [7:0]      byte_sel;

  // Only the leading run of ones in tkeep counts; anything after a hole is dropped.
  always_comb begin
    run      = '0;
    gap      = 1'b0;
    keep_bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bus.in_tkeep[i]) begin
        if (gap) keep_bad = 1'b1;
        else     run = run + ONE;
      end else begin
        gap = 1'b1;
      end
    end
    if (run == '0) keep_bad = 1'b1;
  end

  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (idx_q == W'(i)) byte_sel = data_q[8*i +: 8];
    end
  end

  assign busy       = (state_q == SEND);
  assign at_end     = (idx_q == cnt_q - ONE);
  assign final_beat = busy & bus.out_tready & at_end;
  assign in_xfer    = bus.in_tvalid & bus.in_tready;

  assign bus.in_tready  = aresetn & (~busy | final_beat);
  assign bus.out_tvalid = busy;
  assign bus.out_tdata  = busy ? byte_sel : 8'h00;
  assign bus.out_tlast  = busy & last_q & at_end;
  assign bus.err_keep   = err_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    err_d   = err_q;
    if (in_xfer) begin
      data_d  = bus.in_tdata;
      idx_d   = '0;
      cnt_d   = run;
      last_d  = bus.in_tlast & (run != '0);
      err_d   = err_q | keep_bad;
      state_d = (run != '0) ? SEND : IDLE;
    end else if (busy && bus.out_tready) begin
      if (at_end) state_d = IDLE;
      else        idx_d   = idx_q + ONE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_axis_word_serializer.sv
// Bench for axis_word_serializer: scoreboard of expected bytes plus table and hand sequences.
module tb_axis_word_serializer;
  localparam int N = 5;

  logic aclk = 1'b0;
  logic aresetn;

  axis_word_serializer_if #(.n(N)) bus ();

  axis_word_serializer #(.n(N), .nb(N*8)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
  } exp_t;

  typedef struct {
    logic [39:0] d;
    logic [4:0]  k;
    logic        l;
    int          nbytes;
    logic        err;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n_bytes = 0;
  int   n_lasts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected bytes: leading run of keep ones, last on the final kept byte.
  task automatic push_word(input logic [39:0] d, input logic [4:0] k, input logic l);
    int run = 0;
    while (run < N && k[run]) run++;
    for (int i = 0; i < run; i++) sb.push_back('{d[8*i +: 8], (l && i == run - 1)});
  endtask

  task automatic send_word(input logic [39:0] d, input logic [4:0] k, input logic l);
    int  cyc = 0;
    bit  done = 0;
    bus.in_tdata  = d;
    bus.in_tkeep  = k;
    bus.in_tlast  = l;
    bus.in_tvalid = 1'b1;
    while (!done) begin
      @(negedge aclk);
      if (bus.in_tready) begin
        push_word(d, k, l);
        done = 1;
      end else if (++cyc > 200) begin
        check("in_tready_timeout", 0, 1);
        done = 1;
      end
    end
    @(posedge aclk);
    #1;
    bus.in_tvalid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((sb.size() != 0 || bus.out_tvalid) && cyc < 500) begin
      @(negedge aclk);
      cyc++;
    end
    check("drain_sb_empty", sb.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    sb.delete();
    aresetn = 1'b1;
  endtask

  // Output monitor: scoreboard compare and hold-under-stall check.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic       prev_last = 1'b0;
  exp_t       e;
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", bus.out_tvalid, 1);
        check("hold_dat", bus.out_tdata, prev_dat);
        check("hold_last", bus.out_tlast, prev_last);
      end
      if (bus.out_tvalid && bus.out_tready) begin
        n_bytes++;
        if (bus.out_tlast) n_lasts++;
        if (sb.size() == 0) begin
          check("unexpected_byte", bus.out_tdata, 9'h100);
        end else begin
          e = sb.pop_front();
          check("sb_dat", bus.out_tdata, e.dat);
          check("sb_last", bus.out_tlast, e.last);
        end
      end
      prev_stall = bus.out_tvalid && !bus.out_tready;
      prev_dat   = bus.out_tdata;
      prev_last  = bus.out_tlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    logic [39:0] d;
    logic [63:0] r;
    logic [4:0]  kk;
    int          b0, l0, k, exp_bytes, exp_lasts, w;
    bit          bp_done;

    vt[0] = '{40'h4433221100, 5'h1F, 1'b1, 5, 1'b0};
    vt[1] = '{40'hA5A5A5A5A5, 5'h01, 1'b0, 1, 1'b0};
    vt[2] = '{40'h0123456789, 5'h0F, 1'b1, 4, 1'b0};
    vt[3] = '{40'hEEDDCCBBAA, 5'h07, 1'b1, 3, 1'b0};
    vt[4] = '{40'h1122334455, 5'h00, 1'b1, 0, 1'b1};
    vt[5] = '{40'h5566778899, 5'h0B, 1'b1, 2, 1'b1};

    bus.in_tdata   = '0;
    bus.in_tkeep   = '0;
    bus.in_tlast   = 1'b0;
    bus.in_tvalid  = 1'b0;
    bus.out_tready = 1'b1;
    aresetn        = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_out_tvalid", bus.out_tvalid, 0);
    check("rst_out_tlast", bus.out_tlast, 0);
    check("rst_out_tdata", bus.out_tdata, 0);
    check("rst_err_keep", bus.err_keep, 0);
    check("rst_in_tready", bus.in_tready, 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
    check("rel_in_tready", bus.in_tready, 1);
    @(posedge aclk);
    #1;

    // Single full word: beat-by-beat timing.
    d = 40'h4433221100;
    send_word(d, 5'h1F, 1'b1);
    for (int b = 0; b < 5; b++) begin
      @(negedge aclk);
      check("single_vld", bus.out_tvalid, 1);
      check("single_dat", bus.out_tdata, d[8*b +: 8]);
      check("single_last", bus.out_tlast, b == 4);
      check("single_in_tready", bus.in_tready, b == 4);
    end
    @(negedge aclk);
    check("single_idle_after", bus.out_tvalid, 0);
    drain();

    // Back-to-back words with no gap.
    b0 = n_bytes;
    l0 = n_lasts;
    fork
      begin
        send_word(40'h0908070605, 5'h1F, 1'b0);
        send_word(40'h0E0D0C0B0A, 5'h1F, 1'b1);
      end
      begin
        w = 0;
        @(negedge aclk);
        while (!bus.out_tvalid && w < 20) begin
          @(negedge aclk);
          w++;
        end
        for (int j = 0; j < 10; j++) begin
          check("b2b_vld", bus.out_tvalid, 1);
          check("b2b_last", bus.out_tlast, j == 9);
          if (j < 9) @(negedge aclk);
        end
      end
    join
    drain();
    check("b2b_bytes", n_bytes - b0, 10);
    check("b2b_lasts", n_lasts - l0, 1);
    check("b2b_err", bus.err_keep, 0);

    // Vector table: keep patterns including empty and malformed.
    foreach (vt[i]) begin
      b0 = n_bytes;
      l0 = n_lasts;
      send_word(vt[i].d, vt[i].k, vt[i].l);
      drain();
      check("vec_bytes", n_bytes - b0, vt[i].nbytes);
      check("vec_lasts", n_lasts - l0, (vt[i].l && vt[i].nbytes > 0) ? 1 : 0);
      check("vec_err", bus.err_keep, vt[i].err);
    end

    // Malformed keep: err_keep rises the cycle after accept and sticks.
    do_reset();
    check("mal_err_before", bus.err_keep, 0);
    b0 = n_bytes;
    send_word(40'hCAFEBABE42, 5'h0B, 1'b1);
    check("mal_err_next", bus.err_keep, 1);
    drain();
    repeat (5) @(posedge aclk);
    #1;
    check("mal_bytes", n_bytes - b0, 2);
    check("mal_err_sticky", bus.err_keep, 1);

    // Random backpressure over 20 random well-formed words.
    do_reset();
    b0 = n_bytes;
    l0 = n_lasts;
    exp_bytes = 0;
    exp_lasts = 0;
    bp_done = 0;
    fork
      begin
        for (int wi = 0; wi < 20; wi++) begin
          r  = {$urandom(), $urandom()};
          k  = $urandom_range(1, N);
          kk = 5'((1 << k) - 1);
          exp_bytes += k;
          if (r[40]) exp_lasts++;
          send_word(r[39:0], kk, r[40]);
        end
        bp_done = 1;
      end
      begin
        while (!bp_done) begin
          @(posedge aclk);
          #1;
          bus.out_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_tready = 1'b1;
    drain();
    check("bp_bytes", n_bytes - b0, exp_bytes);
    check("bp_lasts", n_lasts - l0, exp_lasts);

    // Reset in the middle of a word.
    b0 = n_bytes;
    send_word(40'h5544332211, 5'h1F, 1'b1);
    @(posedge aclk);
    @(posedge aclk);
    #2;
    check("mid_bytes_before", n_bytes - b0, 2);
    aresetn = 1'b0;
    #1;
    check("mid_rst_vld", bus.out_tvalid, 0);
    check("mid_rst_in_tready", bus.in_tready, 0);
    sb.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
    check("mid_rel_in_tready", bus.in_tready, 1);
    b0 = n_bytes;
    repeat (10) @(negedge aclk);
    check("mid_no_residual", n_bytes - b0, 0);
    check("mid_idle_vld", bus.out_tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_word_serializer.md
# axis_word_serializer

Downstream stage of the n-byte skid buffer. Consumes nb-bit AXI-Stream words (n bytes each) and emits them one byte per beat, least significant byte first. Honours a per-word byte-keep mask and a packet-end marker. Sustains one byte per clock with no bubble between consecutive words. The downstream byte sink controls flow through out_tready.

## Interface
Parameters:
- n, default 5: bytes per input word; legal range 1..16.
- nb, default n*8: input data width in bits; must equal n*8.

Ports:
- aclk, input, 1: single clock; all logic is on the rising edge.
- aresetn, input, 1: reset, **asynchronous, active-low**.
- in_tdata, input, nb: input word; byte i is bits [8i+7:8i].
- in_tkeep, input, n: byte-valid mask; legal values are contiguous from bit 0.
- in_tlast, input, 1: word is the last of its packet.
- in_tvalid, input, 1: input word valid.
- in_tready, output, 1: serializer can accept a word this cycle.
- out_tdata, output, 8: output byte.
- out_tlast, output, 1: byte is the last byte of its packet.
- out_tvalid, output, 1: output byte valid.
- out_tready, input, 1: sink accepts the byte.
- err_keep, output, 1: sticky flag for a malformed in_tkeep; cleared only by reset.

## Operation
**Handshakes**
- Input transfer occurs when in_tvalid & in_tready.
- Output transfer occurs when out_tvalid & out_tready.
- AXI-Stream rules apply: once out_tvalid is high, out_tvalid, out_tdata and out_tlast hold until the transfer completes.

**Holding state**
- The serializer holds one word: a data register (nb bits), a byte count cnt (1..n), a byte index idx (0..n-1), a last flag, and a busy flag.
- States:
  - IDLE (busy=0): out_tvalid=0, in_tready=1.
  - SEND (busy=1): out_tvalid=1.

**Byte output in SEND**
- out_tdata = byte idx of the data register.
- out_tlast = last flag & (idx == cnt-1).

**in_tready**
- in_tready = !busy | (out_tvalid & out_tready & idx == cnt-1).
- This is combinational from out_tready, which allows back-to-back words.

**On input transfer**
- Load the data register, set idx=0, set last=in_tlast.
- cnt = length of the run of ones starting at in_tkeep[0].
  - If cnt >= 1, enter or stay in SEND.
  - If cnt == 0, the word is discarded: stay in or return to IDLE, and its in_tlast is dropped.

**On output transfer**
- If idx < cnt-1: idx increments.
- Otherwise the word is complete: go to IDLE unless a new word is accepted in the same cycle, in which case reload per the input-transfer rule.

**err_keep**
- Set on any accepted word whose in_tkeep is zero or not of the form 2^k-1.
- For such words, bytes beyond the leading run are dropped.

**Widths and special cases**
- idx and cnt use clog2(n+1) bits.
- idx never wraps past cnt-1.
- n=1: every accepted word with in_tkeep=1 produces exactly one byte. in_tready = !busy | out_tready.

## Timing
- Latency: a word accepted at edge t presents byte 0 on out_tdata after edge t; the first out transfer can be at edge t+1.
- Throughput: a word with k valid bytes occupies exactly k output cycles when out_tready is held high. A consecutive word's byte 0 follows immediately with no idle cycle.
- Backpressure: out_tready low freezes idx and all outputs. in_tready stays 0 while busy.
- Simultaneous final-byte transfer and input transfer in one cycle: the new word's byte 0 appears the next cycle.
- Reset values, applied asynchronously on aresetn low:
  - busy=0, idx=0, cnt=0, last=0.
  - out_tvalid=0, out_tlast=0, out_tdata=0.
  - err_keep=0.
  - in_tready = 1 combinationally once reset is released; in_tready is 0 while aresetn is low.
- Reset mid-word: the partially sent word is lost; no further bytes are emitted after release.
- in_tready and out_tvalid have no combinational path from in_tvalid.

## Test plan
- Single word: n=5, in_tdata=0x44_33_22_11_00, keep=0x1F, last=1, out_tready=1. Required: out bytes 00,11,22,33,44 on 5 consecutive cycles; out_tlast only on 44; in_tready high only during the 44 beat.
- Back-to-back words: two full words with last=0 then last=1, in_tvalid continuous, out_tready=1. Required: 10 contiguous bytes with no gap; out_tlast only on byte 10; err_keep=0.
- Partial keep: keep=0x07, last=1, data=0xEE_DD_CC_BB_AA. Required: bytes AA,BB,CC, with out_tlast on CC. Then keep=0x00 with last=1: accepted, no output, err_keep=0 before this word and 1 after it.
- Malformed keep: keep=0x0B. Required: bytes 0 and 1 only; err_keep=1 from the next cycle until reset.
- Backpressure: random out_tready at 50% over 20 random words. Required: byte sequence matches the scoreboard; outputs stay stable whenever out_tvalid & !out_tready; no byte is lost or duplicated.
- Reset mid-word: assert aresetn=0 after 2 bytes of a 5-byte word. Required: out_tvalid=0 immediately (asynchronously); after release, in_tready=1 and no residual bytes are emitted.
